// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and serializes each byte as 8N1 UART frames.
module fifo_uart_tx #(
    parameter int CLOCK_FREQ          = 125_000_000,
    parameter int BAUD_RATE           = 115_200,
    parameter int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE,
    parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        serial_out,
    output logic        busy,
    output logic [15:0] frames_sent
);
    typedef enum logic [1:0] {IDLE, WAIT, TX} state_t;

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

    if (SYMBOL_EDGE_TIME < 2) begin : g_bad_rate
        $error("fifo_uart_tx: SYMBOL_EDGE_TIME must be at least 2");
    end

    state_t                         state, state_next;
    logic [9:0]                     shift, shift_next;
    logic [CLOCK_COUNTER_WIDTH-1:0] clk_count, clk_count_next;
    logic [3:0]                     bit_count, bit_count_next;
    logic [15:0]                    frame_count, frame_count_next;
    logic                           rd_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '1;
            clk_count   <= '0;
            bit_count   <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            shift       <= shift_next;
            clk_count   <= clk_count_next;
            bit_count   <= bit_count_next;
            frame_count <= frame_count_next;
        end
    end

    always_comb begin
        state_next       = state;
        shift_next       = shift;
        clk_count_next   = clk_count;
        bit_count_next   = bit_count;
        frame_count_next = frame_count;
        rd_req           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_req     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // The FIFO has registered output, so the popped byte is visible only now.
                shift_next     = {1'b1, fifo_dout, 1'b0};
                clk_count_next = '0;
                bit_count_next = '0;
                state_next     = TX;
            end
            TX: begin
                if (clk_count == LAST_COUNT) begin
                    clk_count_next = '0;
                    shift_next     = {1'b1, shift[9:1]};
                    if (bit_count == 4'd9) begin
                        bit_count_next   = '0;
                        frame_count_next = frame_count + 16'd1;
                        state_next       = IDLE;
                    end else begin
                        bit_count_next = bit_count + 4'd1;
                    end
                end else begin
                    clk_count_next = clk_count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fifo_rd_en  = rd_req && !rst;
    assign serial_out  = (state == TX) ? shift[0] : 1'b1;
    assign busy        = state != IDLE;
    assign frames_sent = frame_count;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed stimulus with a line decoder and scoreboard checking each frame.
module tb_fifo_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic        serial_out;
    logic        busy;
    logic [15:0] frames_sent;

    fifo_uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .serial_out(serial_out), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rd = -100;
    int rd_cycs[$];
    logic [7:0] exp_q[$];
    logic [15:0] exp_frames = 16'h0000;

    logic [7:0] mem [256];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rp[7:0]];
            rp <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            chk("rd_while_busy_or_rst", {30'd0, busy, rst}, 0);
            last_rd = cyc;
            rd_cycs.push_back(cyc);
        end
    end

    // Line decoder: frame t=0 is the first start-bit cycle, t=100 the first IDLE cycle after it.
    bit dec_active = 0;
    int dec_t = 0;
    logic cur;
    bit stable;
    logic [9:0] bits;
    always @(negedge clk) begin
        if (rst) dec_active = 0;
        else if (!dec_active) begin
            if (serial_out == 1'b0) begin
                dec_active = 1;
                dec_t = 0;
                stable = 1;
                chk("start_latency", cyc - last_rd, 2);
            end
        end else dec_t++;
        if (dec_active && !rst) begin
            if (dec_t < 100) begin
                if (dec_t % 10 == 0) begin
                    cur = serial_out;
                    bits[dec_t / 10] = serial_out;
                end else if (serial_out !== cur) stable = 0;
            end else begin
                chk("bit_stable", {31'd0, stable}, 1);
                chk("start_bit", {31'd0, bits[0]}, 0);
                chk("stop_bit", {31'd0, bits[9]}, 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got byte %0h with none expected", bits[8:1]);
                end else chk("byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
                exp_frames = exp_frames + 16'd1;
                chk("frames_sent", {16'd0, frames_sent}, {16'd0, exp_frames});
                chk("busy_after_frame", {31'd0, busy}, 0);
                dec_active = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[7:0]] = b;
        wp = wp + 1;
        exp_q.push_back(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !dec_active && !busy && fifo_empty) break;
            tick();
        end
        chk("drain", {29'd0, exp_q.size() != 0, dec_active, busy}, 0);
        repeat (3) tick();
    endtask

    task automatic wait_dec(input int t);
        for (int i = 0; i < 2000; i++) begin
            if (dec_active && dec_t == t) break;
            tick();
        end
        chk("reach_frame_time", {31'd0, dec_active && dec_t == t}, 1);
    endtask

    initial begin
        int base;
        int bad;
        repeat (2) tick();
        chk("rst_serial_out", {31'd0, serial_out}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        chk("rst_frames", {16'd0, frames_sent}, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_frames", {16'd0, frames_sent}, 0);

        // Reset during data bit 3 of 8'h3C, then C3 must go out intact.
        base = rd_cycs.size();
        push(8'h3C);
        wait_dec(42);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("midrst_serial_out", {31'd0, serial_out}, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_frames", {16'd0, frames_sent}, {16'd0, exp_frames});
        push(8'hC3);
        chk("midrst_no_rd", {31'd0, fifo_rd_en}, 0);
        tick();
        chk("midrst_no_rd_held", {31'd0, fifo_rd_en}, 0);
        rst = 1'b0;
        drain();
        chk("midrst_rd_count", rd_cycs.size() - base, 2);

        base = rd_cycs.size();
        push(8'hA5);
        drain();
        chk("single_rd_count", rd_cycs.size() - base, 1);
        chk("single_frames", {16'd0, frames_sent}, 2);

        base = rd_cycs.size();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        drain();
        chk("burst_rd_count", rd_cycs.size() - base, 3);
        if (rd_cycs.size() - base == 3) begin
            chk("burst_gap_1", rd_cycs[base + 1] - rd_cycs[base], 102);
            chk("burst_gap_2", rd_cycs[base + 2] - rd_cycs[base + 1], 102);
        end
        chk("burst_frames", {16'd0, frames_sent}, 5);

        // FIFO refills mid stop bit: next read belongs to the first IDLE cycle.
        base = rd_cycs.size();
        push(8'h5A);
        wait_dec(95);
        push(8'h96);
        drain();
        chk("refill_rd_count", rd_cycs.size() - base, 2);
        if (rd_cycs.size() - base == 2) chk("refill_gap", rd_cycs[base + 1] - rd_cycs[base], 102);

        force dut.frame_count = 16'hFFFF;
        tick();
        release dut.frame_count;
        tick();
        chk("preload_frames", {16'd0, frames_sent}, 32'h0000FFFF);
        exp_frames = 16'hFFFF;
        push(8'h81);
        drain();
        chk("wrap_frames", {16'd0, frames_sent}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer of the lab5 byte FIFO. It pulls bytes from the FIFO read port whenever the FIFO is non-empty and serializes each one onto a UART line as 8N1: one start bit, 8 data bits LSB first, one stop bit. The FIFO absorbs bursts from the producer side, and this block drains it at the baud rate.

## Interface
- CLOCK_FREQ, 125_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE: cycles per bit (integer division, truncating); must be ≥2.
- CLOCK_COUNTER_WIDTH, $clog2(SYMBOL_EDGE_TIME): width of the bit-period counter.

- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data; valid the cycle after a rd_en accepted while non-empty.
- fifo_rd_en  output  1  FIFO read strobe, combinational.
- serial_out  output  1  UART TX line; idles high.
- busy  output  1  high whenever state ≠ IDLE.
- frames_sent  output  16  count of completed frames; wraps modulo 2^16.

## Operation
- States: IDLE, WAIT, TX.
- fifo_rd_en = !rst && state==IDLE && !fifo_empty. It is never asserted in WAIT or TX.
- IDLE:
  - serial_out = 1.
  - If !fifo_empty, assert fifo_rd_en this cycle and go to WAIT. Otherwise stay in IDLE.
- WAIT (exactly 1 cycle):
  - fifo_dout now holds the popped byte.
  - At the closing edge, load the 10-bit shift register with {1'b1, fifo_dout, 1'b0}.
  - Clear the clock counter and bit counter, then go to TX.
  - fifo_empty is ignored in this state.
- TX:
  - serial_out = shift[0].
  - The clock counter counts 0..SYMBOL_EDGE_TIME-1.
  - On the last count: shift right with 1 filling the MSB, clear the clock counter, and increment the bit counter (0..9).
  - When bit 9 (stop) finishes its full period: increment frames_sent and go to IDLE.
- serial_out is driven from registered state only: the shift register, plus a forced 1 in IDLE/WAIT.
- Shift register reset value is all ones.
- The block never reads more than one byte per frame and never holds more than one byte internally.

## Timing
- Reset: state=IDLE, serial_out=1, busy=0, fifo_rd_en=0, frames_sent=0, all counters 0.
- Reset mid-frame: at the next edge the block is in IDLE, serial_out=1, and the in-flight byte is dropped. No rd_en is issued while rst is high.
- Cycle N: IDLE with !fifo_empty, so fifo_rd_en=1.
- N+1: WAIT, busy=1, serial_out=1.
- N+2: start bit, serial_out=0, lasting SYMBOL_EDGE_TIME cycles.
- Data bit k occupies cycles N+2+(k+1)·SYMBOL_EDGE_TIME onward.
- The stop bit ends at N+2+10·SYMBOL_EDGE_TIME − 1.
- The next edge returns to IDLE, and frames_sent increments on that same edge.
- Frame length is 10·SYMBOL_EDGE_TIME cycles of line time.
- Back-to-back bytes: 2 idle-high cycles (IDLE + WAIT) between the stop bit and the next start bit. Gross occupancy is 10·SYMBOL_EDGE_TIME+2 cycles per byte.
- fifo_empty rising during TX has no effect. fifo_empty falling during TX is acted on only once IDLE is reached.
- frames_sent at 16'hFFFF wraps to 0 on the next completed frame.

## Test plan
Bench parameters: CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10. The bench uses a behavioural FIFO model with registered dout.

1. Reset and idle: hold rst 2 cycles with fifo_empty=1, then run 50 cycles. Required: serial_out=1, busy=0, fifo_rd_en never high, frames_sent=0.
2. Single byte 8'hA5: exactly one rd_en pulse. Line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles, start bit beginning 2 cycles after the rd_en cycle. busy returns to 0 and frames_sent=1 after 100 line cycles.
3. Burst 8'h00, 8'hFF, 8'h55 preloaded: three rd_en pulses spaced 102 cycles apart. Decoded bytes match in order, frames_sent=3, and rd_en is never asserted while busy.
4. Empty toggling: the FIFO becomes non-empty in the middle of the stop bit. The next rd_en must occur in the first IDLE cycle after the stop bit, with no early read.
5. Reset mid-frame: assert rst during data bit 3 of 8'h3C. serial_out=1 on the next cycle, frames_sent is unchanged, and the next byte after reset is transmitted intact.
6. Counter wrap: force or preload frames_sent=16'hFFFF and send one byte. frames_sent=0 after the stop bit.
